io_uart: RTL and testbench

Memory-mapped 8N1 UART peripheral on the IO side of the data-bus address decoder. It consumes the decoder's IO port: addresses with bit 31 set, delivered with bit 31 cleared, plus the read/write enables. It provides a transmit register, a one-byte receive holding register, a status register and a programmable baud divisor. Read data is combinational so a single-cycle core can load it in the same cycle.

---
 rtl/io_uart_pkg.sv | 30 +++
 rtl/io_uart_bit_timer.sv | 34 +++
 rtl/io_uart.sv | 201 ++++++++++++++++++++
 tb/tb_io_uart.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
// Shared constants and types for the memory-mapped 8N1 UART.
// Register offsets, STATUS bit positions, FSM state encoding and divisor floor.
package io_uart_pkg;

    localparam logic [3:0] ADDR_TXDATA  = 4'h0;
    localparam logic [3:0] ADDR_RXDATA  = 4'h4;
    localparam logic [3:0] ADDR_STATUS  = 4'h8;
    localparam logic [3:0] ADDR_DIVISOR = 4'hC;

    localparam int STAT_TX_BUSY      = 0;
    localparam int STAT_RX_VALID     = 1;
    localparam int STAT_RX_OVERRUN   = 2;
    localparam int STAT_RX_FRAME_ERR = 3;
    localparam int STAT_TX_DROP      = 4;

    localparam int unsigned MIN_DIVISOR = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    function automatic logic [15:0] clamp_divisor(input logic [15:0] value,
                                                  input logic [15:0] floor_value);
        return (value < floor_value) ? floor_value : value;
    endfunction

endpackage

// File: rtl/io_uart_bit_timer.sv
// Bit-period down-counter: load arms it for a full (or half) divisor period,
// tick pulses for one cycle in the last cycle of that period.
module io_uart_bit_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        half,
    input  logic [15:0] divisor,
    output logic        tick
);
    logic [15:0] count;
    logic        armed;
    logic [15:0] span;

    assign span = half ? {1'b0, divisor[15:1]} : divisor;
    assign tick = armed && (count == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'd0;
            armed <= 1'b0;
        end else if (load) begin
            count <= span - 16'd1;
            armed <= 1'b1;
        end else if (armed) begin
            if (count == 16'd0) begin
                armed <= 1'b0;
            end else begin
                count <= count - 16'd1;
            end
        end
    end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART: TXDATA / RXDATA / STATUS / DIVISOR, combinational read data.
// state    | meaning
// ST_IDLE  | line idle, waiting for a TX write or an RX falling edge
// ST_START | start bit (TX drives 0; RX waits half a bit then re-checks the line)
// ST_DATA  | eight data bits, LSB first
// ST_STOP  | stop bit (TX drives 1; RX samples it and delivers the byte)
module io_uart #(
    parameter int unsigned DEFAULT_DIVISOR = 868,
    parameter int unsigned MIN_DIVISOR     = io_uart_pkg::MIN_DIVISOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] io_address,
    input  logic        io_read_en,
    input  logic        io_write_en,
    input  logic [31:0] io_write_value,
    output logic [31:0] io_read_value,
    input  logic        uart_rx,
    output logic        uart_tx
);
    import io_uart_pkg::*;

    localparam logic [15:0] DIV_RESET = 16'(DEFAULT_DIVISOR);
    localparam logic [15:0] DIV_MIN   = 16'(MIN_DIVISOR);

    logic        hit;
    logic [1:0]  sel;
    logic        wr_tx, wr_status, wr_div, rd_rx;
    logic [15:0] divisor;

    assign hit       = (io_address[31:4] == 28'd0);
    assign sel       = io_address[3:2];
    assign wr_tx     = io_write_en && hit && (sel == ADDR_TXDATA[3:2]);
    assign wr_status = io_write_en && hit && (sel == ADDR_STATUS[3:2]);
    assign wr_div    = io_write_en && hit && (sel == ADDR_DIVISOR[3:2]);
    assign rd_rx     = io_read_en  && hit && (sel == ADDR_RXDATA[3:2]);

    logic unused_bits;
    assign unused_bits = ^{io_address[1:0], io_write_value[31:16]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor <= DIV_RESET;
        end else if (wr_div) begin
            divisor <= clamp_divisor(io_write_value[15:0], DIV_MIN);
        end
    end

    uart_state_e tx_state;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_cnt;
    logic [15:0] tx_div;
    logic        tx_busy, tx_start, tx_load, tx_tick, tx_drop;

    assign tx_busy  = (tx_state != ST_IDLE);
    assign tx_start = wr_tx && !tx_busy;
    assign tx_load  = tx_start || (tx_tick && (tx_state inside {ST_START, ST_DATA}));

    io_uart_bit_timer u_tx_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tx_load),
        .half    (1'b0),
        .divisor (tx_busy ? tx_div : divisor),
        .tick    (tx_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= ST_IDLE;
            tx_shift <= 8'd0;
            tx_cnt   <= 3'd0;
            tx_div   <= DIV_RESET;
            tx_drop  <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: if (tx_start) begin
                    tx_state <= ST_START;
                    tx_shift <= io_write_value[7:0];
                    tx_div   <= divisor;
                    uart_tx  <= 1'b0;
                end
                ST_START: if (tx_tick) begin
                    tx_state <= ST_DATA;
                    tx_cnt   <= 3'd0;
                    uart_tx  <= tx_shift[0];
                    tx_shift <= {1'b0, tx_shift[7:1]};
                end
                ST_DATA: if (tx_tick) begin
                    if (tx_cnt == 3'd7) begin
                        tx_state <= ST_STOP;
                        uart_tx  <= 1'b1;
                    end else begin
                        tx_cnt   <= tx_cnt + 3'd1;
                        uart_tx  <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end
                end
                ST_STOP: if (tx_tick) begin
                    tx_state <= ST_IDLE;
                end
            endcase
            // set after clear so a simultaneous drop wins over write-1-clear
            if (wr_status && io_write_value[STAT_TX_DROP]) tx_drop <= 1'b0;
            if (wr_tx && tx_busy) tx_drop <= 1'b1;
        end
    end

    logic        rx_meta, rx_sync, rx_prev, rx_fall;
    uart_state_e rx_state;
    logic [7:0]  rx_shift, rx_byte;
    logic [2:0]  rx_cnt;
    logic [15:0] rx_div;
    logic        rx_load, rx_tick, rx_done;
    logic        rx_valid, rx_overrun, rx_frame_err;

    assign rx_fall = rx_prev && !rx_sync;
    assign rx_done = (rx_state == ST_STOP) && rx_tick;
    assign rx_load = ((rx_state == ST_IDLE)  && rx_fall) ||
                     ((rx_state == ST_START) && rx_tick && !rx_sync) ||
                     ((rx_state == ST_DATA)  && rx_tick);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    io_uart_bit_timer u_rx_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (rx_load),
        .half    (rx_state == ST_IDLE),
        .divisor ((rx_state == ST_IDLE) ? divisor : rx_div),
        .tick    (rx_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state     <= ST_IDLE;
            rx_shift     <= 8'd0;
            rx_cnt       <= 3'd0;
            rx_div       <= DIV_RESET;
            rx_byte      <= 8'd0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            case (rx_state)
                ST_IDLE: if (rx_fall) begin
                    rx_state <= ST_START;
                    rx_div   <= divisor;
                end
                ST_START: if (rx_tick) begin
                    rx_state <= rx_sync ? ST_IDLE : ST_DATA;
                    rx_cnt   <= 3'd0;
                end
                ST_DATA: if (rx_tick) begin
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                    if (rx_cnt == 3'd7) rx_state <= ST_STOP;
                    else                rx_cnt   <= rx_cnt + 3'd1;
                end
                ST_STOP: if (rx_tick) begin
                    rx_state <= ST_IDLE;
                end
            endcase
            if (wr_status && io_write_value[STAT_RX_OVERRUN])   rx_overrun   <= 1'b0;
            if (wr_status && io_write_value[STAT_RX_FRAME_ERR]) rx_frame_err <= 1'b0;
            // a read landing on the completion edge consumes the old byte, not the new one
            if (rx_done) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rd_rx) rx_overrun   <= 1'b1;
                if (!rx_sync)           rx_frame_err <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        io_read_value = 32'd0;
        if (io_read_en && hit) begin
            case (sel)
                ADDR_RXDATA[3:2]:  io_read_value = {24'd0, rx_byte};
                ADDR_STATUS[3:2]:  io_read_value = {27'd0, tx_drop, rx_frame_err,
                                                    rx_overrun, rx_valid, tx_busy};
                ADDR_DIVISOR[3:2]: io_read_value = {16'd0, divisor};
                default:           io_read_value = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_uart.sv
// Self-checking bench for io_uart: bus tasks, per-cycle TX line capture with
// mid-bit decoding, and a flag/byte model of the receiver fed by a serial driver.
module tb_io_uart;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] io_address;
    logic        io_read_en;
    logic        io_write_en;
    logic [31:0] io_write_value;
    logic [31:0] io_read_value;
    logic        uart_rx;
    logic        uart_tx;

    always #5 clk = ~clk;

    io_uart #(.DEFAULT_DIVISOR(868), .MIN_DIVISOR(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .io_address     (io_address),
        .io_read_en     (io_read_en),
        .io_write_en    (io_write_en),
        .io_write_value (io_write_value),
        .io_read_value  (io_read_value),
        .uart_rx        (uart_rx),
        .uart_tx        (uart_tx)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   line_q[$];
    logic [7:0] m_byte;
    bit   m_valid, m_ovr, m_ferr, m_drop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
        io_address     = a;
        io_write_value = v;
        io_write_en    = 1'b1;
        @(posedge clk);
        #1;
        io_write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        io_address = a;
        io_read_en = 1'b1;
        #2;
        d = io_read_value;
        @(posedge clk);
        #1;
        io_read_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check_eq(tag, d, exp);
    endtask

    function automatic logic [31:0] exp_status();
        return {27'd0, m_drop, m_ferr, m_ovr, m_valid, 1'b0};
    endfunction

    // serial frame bit k: start, 8 data bits LSB first, stop
    function automatic bit frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic watch_tx(input int n, output int busy);
        busy       = 0;
        io_address = 32'h8;
        io_read_en = 1'b1;
        repeat (n) begin
            #2;
            line_q.push_back(uart_tx);
            if (io_read_value[0]) busy++;
            @(posedge clk);
            #1;
        end
        io_read_en = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b, input int div, input int trail);
        int errs = 0;
        logic [7:0] dec;
        bit expb;
        check_eq({tag, "_len"}, line_q.size(), 10*div + trail);
        for (int c = 0; c < line_q.size(); c++) begin
            expb = (c < 10*div) ? frame_bit(b, c / div) : 1'b1;
            if (line_q[c] != expb) errs++;
        end
        for (int k = 0; k < 8; k++) begin
            int idx = (k + 1)*div + div/2;
            dec[k] = (idx < line_q.size()) ? line_q[idx] : 1'bx;
        end
        check_eq({tag, "_cycles"}, errs, 0);
        check_eq({tag, "_byte"}, {24'd0, dec}, {24'd0, b});
    endtask

    task automatic send_frame(input logic [7:0] b, input int div, input bit stop);
        for (int k = 0; k < 10; k++) begin
            uart_rx = (k == 9) ? stop : frame_bit(b, k);
            repeat (div) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    task automatic rx_model_done(input logic [7:0] b, input bit stop, input bit read_same);
        if (m_valid && !read_same) m_ovr = 1'b1;
        if (!stop) m_ferr = 1'b1;
        m_byte  = b;
        m_valid = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic [31:0] d;
        int          busy, div, extra;
        bit          stop, do_read;

        rst_n = 1'b0; io_address = '0; io_read_en = 1'b0; io_write_en = 1'b0;
        io_write_value = '0; uart_rx = 1'b1;
        m_byte = 8'd0; m_valid = 0; m_ovr = 0; m_ferr = 0; m_drop = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        check_eq("rst_tx", uart_tx, 1);
        read_check("rst_status", 32'h8, 32'h0);
        read_check("rst_divisor", 32'hC, 32'd868);
        read_check("rst_rxdata", 32'h4, 32'h0);
        read_check("txdata_reads_zero", 32'h0, 32'h0);
        io_address = 32'hC;
        #1;
        check_eq("read_en_low", io_read_value, 32'h0);

        bus_write(32'hC, 32'd2);
        read_check("div_clamp", 32'hC, 32'd4);

        line_q.delete();
        bus_write(32'h0, 32'hA5);
        watch_tx(44, busy);
        check_frame("tx_a5", 8'hA5, 4, 4);
        check_eq("tx_a5_busy", busy, 40);

        line_q.delete();
        bus_write(32'h0, 32'h11);
        line_q.push_back(uart_tx);
        bus_write(32'h0, 32'h22);
        m_drop = 1'b1;
        watch_tx(47, busy);
        check_frame("tx_drop", 8'h11, 4, 8);
        read_check("drop_flag", 32'h8, exp_status());
        bus_write(32'h8, 32'h10);
        m_drop = 1'b0;
        read_check("drop_clear", 32'h8, exp_status());

        line_q.delete();
        bus_write(32'h0, 32'h3C);
        line_q.push_back(uart_tx);
        bus_write(32'hC, 32'd6);
        watch_tx(43, busy);
        check_frame("tx_div_latched", 8'h3C, 4, 4);
        read_check("div_written_mid", 32'hC, 32'd6);

        for (int rep = 0; rep < 2; rep++) begin
            div = $urandom_range(4, 7);
            bus_write(32'hC, div);
            read_check("chain_div", 32'hC, div);
            for (int f = 0; f < 3; f++) begin
                b = 8'($urandom);
                line_q.delete();
                bus_write(32'h0, {24'd0, b});
                watch_tx(10*div + ((f == 2) ? 2*div : 0), busy);
                check_frame("chain_tx", b, div, (f == 2) ? 2*div : 0);
                check_eq("chain_busy", busy, 10*div);
            end
        end

        bus_write(32'hC, 32'd4);
        div = 4;
        send_frame(8'h3C, div, 1'b1);
        rx_model_done(8'h3C, 1'b1, 1'b0);
        idle(4);
        read_check("rx_status", 32'h8, exp_status());
        read_check("rx_data", 32'h4, {24'd0, m_byte});
        m_valid = 1'b0;
        read_check("rx_valid_cleared", 32'h8, exp_status());

        send_frame(8'h55, div, 1'b1);
        rx_model_done(8'h55, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h66, div, 1'b1);
        rx_model_done(8'h66, 1'b1, 1'b0);
        idle(4);
        read_check("ovr_status", 32'h8, exp_status());
        read_check("ovr_data", 32'h4, {24'd0, m_byte});
        m_valid = 1'b0;
        bus_write(32'h8, 32'h4);
        m_ovr = 1'b0;
        read_check("ovr_clear", 32'h8, exp_status());

        send_frame(8'h81, div, 1'b0);
        rx_model_done(8'h81, 1'b0, 1'b0);
        idle(4);
        read_check("ferr_status", 32'h8, exp_status());
        read_check("ferr_data", 32'h4, {24'd0, m_byte});
        m_valid = 1'b0;
        bus_write(32'h8, 32'h8);
        m_ferr = 1'b0;
        read_check("ferr_clear", 32'h8, exp_status());

        uart_rx = 1'b0;
        idle(1);
        uart_rx = 1'b1;
        idle(16);
        read_check("rx_glitch", 32'h8, exp_status());

        send_frame(8'hA1, div, 1'b1);
        rx_model_done(8'hA1, 1'b1, 1'b0);
        idle(4);
        send_frame(8'hB2, div, 1'b1);
        extra = 9*div + div/2 + 3 - 10*div - 1;
        idle(extra);
        bus_read(32'h4, d);
        check_eq("collide_old_byte", d, {24'd0, m_byte});
        rx_model_done(8'hB2, 1'b1, 1'b1);
        read_check("collide_status", 32'h8, exp_status());
        read_check("collide_new_byte", 32'h4, {24'd0, m_byte});
        m_valid = 1'b0;

        read_check("unmapped_read", 32'h10, 32'h0);
        read_check("unmapped_high", 32'h0100_0008, 32'h0);
        bus_write(32'h10, 32'h5A);
        bus_write(32'h1C, 32'd100);
        idle(2);
        check_eq("unmapped_tx_idle", uart_tx, 1);
        read_check("unmapped_status", 32'h8, exp_status());
        read_check("unmapped_div", 32'hC, 32'd4);

        io_address = 32'hC; io_write_value = 32'd9;
        io_read_en = 1'b1; io_write_en = 1'b1;
        #2;
        d = io_read_value;
        @(posedge clk);
        #1;
        io_read_en = 1'b0; io_write_en = 1'b0;
        check_eq("rw_same_cycle_old", d, 32'd4);
        read_check("rw_same_cycle_new", 32'hC, 32'd9);
        bus_write(32'hC, 32'd4);

        for (int i = 0; i < 6; i++) begin
            b       = 8'($urandom);
            stop    = ($urandom_range(0, 3) != 0);
            do_read = $urandom_range(0, 1);
            send_frame(b, div, stop);
            rx_model_done(b, stop, 1'b0);
            idle(4);
            read_check("rnd_rx_status", 32'h8, exp_status());
            if (do_read) begin
                read_check("rnd_rx_data", 32'h4, {24'd0, m_byte});
                m_valid = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) begin
                bus_write(32'h8, 32'h1C);
                m_ovr = 1'b0; m_ferr = 1'b0; m_drop = 1'b0;
            end
        end
        read_check("rnd_rx_last", 32'h4, {24'd0, m_byte});

        bus_write(32'h0, 32'h00);
        uart_rx = 1'b0;
        idle(5);
        check_eq("pre_reset_tx_low", uart_tx, 0);
        rst_n = 1'b0;
        #1;
        check_eq("reset_mid_frame_tx", uart_tx, 1);
        idle(2);
        uart_rx = 1'b1;
        idle(1);
        rst_n = 1'b1;
        m_byte = 8'd0; m_valid = 0; m_ovr = 0; m_ferr = 0; m_drop = 0;
        idle(20);
        check_eq("post_reset_tx", uart_tx, 1);
        read_check("post_reset_status", 32'h8, exp_status());
        read_check("post_reset_div", 32'hC, 32'd868);
        read_check("post_reset_rxdata", 32'h4, {24'd0, m_byte});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
